div_iter: RTL

- Multi-cycle restoring integer divider that sits directly downstream of the ALU operand path.
- Each iteration it feeds one trial subtraction (partial remainder minus divisor) into an adder instance. It then consumes that adder's result and carry to decide the quotient bit.
- It gives the single-cycle core DIV/DIVU/REM/REMU support through a start/done handshake, so the core can stall while the divider is busy.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_adder.sv | 22 ++
 rtl/div_iter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
package div_pkg;

    localparam int unsigned DIV_DW = 32;
    localparam int unsigned CNT_W  = $clog2(DIV_DW) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/div_adder.sv
// Ripple-free behavioural adder with carry, zero and signed-overflow flags.
module div_adder #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum_c,
    output logic         cout_c,
    output logic         zero_c,
    output logic         ovf_c
);

    logic [W:0] full;

    assign full   = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    assign sum_c  = full[W-1:0];
    assign cout_c = full[W];
    assign zero_c = (full[W-1:0] == '0);
    assign ovf_c  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);

endmodule

// File: rtl/div_iter.sv
// Multi-cycle restoring divider (DIV/DIVU/REM/REMU) with start/done handshake.
// Signed operation is built only when DIV_SIGNED_EN is defined.
module div_iter
    import div_pkg::*;
#(
    parameter int unsigned DW = DIV_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          kill,
    input  logic          is_signed,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [DW-1:0] remainder,
    output logic          div_zero
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    rem_q, rem_d;
    logic [DW-1:0]    quo_q, quo_d;
    logic [DW-1:0]    dsr_q, dsr_d;
    logic [DW-1:0]    quotient_q, quotient_d;
    logic [DW-1:0]    remainder_q, remainder_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;

    logic [DW-1:0]    dividend_abs, divisor_abs;
    logic [DW-1:0]    trial_opa, trial_sum;
    logic             trial_cout, no_borrow;
    logic             unused_zero, unused_ovf;

`ifdef DIV_SIGNED_EN
    localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};

    logic neg_quo_q, neg_quo_d;
    logic neg_rem_q, neg_rem_d;
    logic sgn_ovf;

    function automatic logic [DW-1:0] negate(input logic [DW-1:0] x);
        return ~x + DW'(1);
    endfunction

    assign dividend_abs = (is_signed && dividend[DW-1]) ? negate(dividend) : dividend;
    assign divisor_abs  = (is_signed && divisor[DW-1])  ? negate(divisor)  : divisor;
    assign sgn_ovf      = is_signed && (dividend == MIN_NEG) && (divisor == '1);
`else
    logic unused_is_signed;

    assign unused_is_signed = is_signed;
    assign dividend_abs     = dividend;
    assign divisor_abs      = divisor;
`endif

    // Trial subtraction: shifted partial remainder minus divisor magnitude.
    assign trial_opa = {rem_q[DW-2:0], quo_q[DW-1]};

    div_adder #(
        .W (DW)
    ) u_trial (
        .a      (trial_opa),
        .b      (~dsr_q),
        .cin    (1'b1),
        .sum_c  (trial_sum),
        .cout_c (trial_cout),
        .zero_c (unused_zero),
        .ovf_c  (unused_ovf)
    );

    // A remainder bit shifted out of the top always exceeds the divisor.
    assign no_borrow = trial_cout | rem_q[DW-1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dsr_d       = dsr_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
`ifdef DIV_SIGNED_EN
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        div_zero_d  = 1'b1;
                        state_d     = S_DONE;
                    end
`ifdef DIV_SIGNED_EN
                    else if (sgn_ovf) begin
                        quotient_d  = dividend;
                        remainder_d = '0;
                        div_zero_d  = 1'b0;
                        state_d     = S_DONE;
                    end
`endif
                    else begin
                        rem_d   = '0;
                        quo_d   = dividend_abs;
                        dsr_d   = divisor_abs;
                        cnt_d   = CNT_W'(DW - 1);
`ifdef DIV_SIGNED_EN
                        neg_quo_d = is_signed && (dividend[DW-1] ^ divisor[DW-1]);
                        neg_rem_d = is_signed && dividend[DW-1];
`endif
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = no_borrow ? trial_sum : trial_opa;
                    quo_d = {quo_q[DW-2:0], no_borrow};
                    if (cnt_q == '0) begin
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            S_FIX: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
`ifdef DIV_SIGNED_EN
                    quotient_d  = neg_quo_q ? negate(quo_q) : quo_q;
                    remainder_d = neg_rem_q ? negate(rem_q) : rem_q;
`else
                    quotient_d  = quo_q;
                    remainder_d = rem_q;
`endif
                    div_zero_d  = 1'b0;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_CALC) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            div_zero_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dsr_q       <= dsr_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            div_zero_q  <= div_zero_d;
`ifdef DIV_SIGNED_EN
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;

endmodule
